// File: rtl/cwt_mul_ctrl.sv
// cwt_mul_ctrl: captures one FFT frame into the frame BRAM and replays it once per wavelet scale
module cwt_mul_ctrl #(
    parameter int N       = 1024,
    parameter int J1      = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fft_ready_i,
    input  logic                       dl_busy_i,
    output logic                       src_sel,
    output logic                       bram_en,
    output logic                       bram_we,
    output logic [$clog2(N)-1:0]       bram_addr,
    output logic [$clog2(N*J1)-1:0]    daughter_addr,
    output logic [$clog2(J1)-1:0]      scale_o,
    output logic                       out_valid_o,
    output logic                       scale_done_o,
    output logic                       frame_done_o,
    output logic                       overrun_o,
    output logic                       busy_o
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(J1);
    localparam int D  = MUL_LAT + 1;
    localparam int DW = $clog2(D + 1);
    localparam logic [AW-1:0] N_LAST = AW'(N - 1);
    localparam logic [SW-1:0] S_LAST = SW'(J1 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(D - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DL, RUN, DRAIN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] n, n_nx;
    logic [SW-1:0] scale, scale_nx;
    logic [DW-1:0] d, d_nx;
    logic [D-1:0]  vld_sr;

    // state, counters and the read-to-product latency line
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n      <= '0;
            scale  <= '0;
            d      <= '0;
            vld_sr <= '0;
        end else begin
            state  <= state_nx;
            n      <= n_nx;
            scale  <= scale_nx;
            d      <= d_nx;
            vld_sr <= D'({vld_sr, state == RUN});
        end
    end

    // next-state, counter updates and BRAM/BROM port drive
    always_comb begin
        state_nx      = state;
        n_nx          = n;
        scale_nx      = scale;
        d_nx          = d;
        bram_en       = 1'b0;
        bram_we       = 1'b0;
        bram_addr     = '0;
        daughter_addr = '0;
        scale_done_o  = 1'b0;
        frame_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (fft_ready_i) begin
                    bram_en  = 1'b1;
                    bram_we  = 1'b1;
                    n_nx     = AW'(1);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                bram_addr = n;
                if (fft_ready_i) begin
                    bram_en  = 1'b1;
                    bram_we  = 1'b1;
                    n_nx     = n + 1'b1;
                    if (n == N_LAST) begin
                        n_nx     = '0;
                        scale_nx = '0;
                        state_nx = WAIT_DL;
                    end
                end
            end
            WAIT_DL: state_nx = dl_busy_i ? WAIT_DL : RUN;
            RUN: begin
                bram_en       = 1'b1;
                bram_addr     = n;
                daughter_addr = {scale, n};
                n_nx          = n + 1'b1;
                if (n == N_LAST) begin
                    n_nx     = '0;
                    d_nx     = '0;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                d_nx = d + 1'b1;
                if (d == D_LAST) begin
                    scale_done_o = 1'b1;
                    d_nx         = '0;
                    frame_done_o = scale == S_LAST;
                    scale_nx     = scale == S_LAST ? scale : scale + 1'b1;
                    state_nx     = scale == S_LAST ? IDLE : WAIT_DL;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign src_sel     = state inside {WAIT_DL, RUN, DRAIN};
    assign overrun_o   = src_sel & fft_ready_i;
    assign busy_o      = state != IDLE;
    assign scale_o     = scale;
    assign out_valid_o = vld_sr[D-1];
endmodule

// File: tb/tb_cwt_mul_ctrl.sv
// tb_cwt_mul_ctrl: directed cycle-accurate checks of the CWT multiply sequencer
module tb_cwt_mul_ctrl;
    localparam int N  = 16;
    localparam int J1 = 4;
    localparam int ML = 3;
    localparam int D  = ML + 1;

    logic       clk = 0, rst = 1, fft_ready_i = 0, dl_busy_i = 0;
    logic       src_sel, bram_en, bram_we, out_valid_o, scale_done_o, frame_done_o, overrun_o, busy_o;
    logic [3:0] bram_addr;
    logic [5:0] daughter_addr;
    logic [1:0] scale_o;

    int errs = 0, checks = 0;
    int n_valid = 0, n_sd = 0, n_fd = 0, n_ovr = 0, cyc = 0;

    cwt_mul_ctrl #(.N(N), .J1(J1), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .fft_ready_i(fft_ready_i), .dl_busy_i(dl_busy_i),
        .src_sel(src_sel), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .daughter_addr(daughter_addr), .scale_o(scale_o), .out_valid_o(out_valid_o),
        .scale_done_o(scale_done_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // strobe tallies and a cycle count, taken mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            n_valid <= n_valid + int'(out_valid_o);
            n_sd    <= n_sd + int'(scale_done_o);
            n_fd    <= n_fd + int'(frame_done_o);
            n_ovr   <= n_ovr + int'(overrun_o);
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic int all_out();
        return int'({src_sel, bram_en, bram_we, bram_addr, daughter_addr, scale_o,
                     out_valid_o, scale_done_o, frame_done_o, overrun_o, busy_o});
    endfunction

    task automatic load_frame(input bit gap);
        for (int i = 0; i < N; i++) begin
            fft_ready_i = 1;
            smp();
            check("ld_we", int'({bram_en, bram_we}), 3);
            check("ld_addr", int'(bram_addr), i);
            check("ld_sel", int'(src_sel), 0);
            step();
            if (gap && i < N - 1) begin
                fft_ready_i = 0;
                smp();
                check("gap_en", int'(bram_en), 0);
                check("gap_busy", int'(busy_o), 1);
                step();
            end
        end
        fft_ready_i = 0;
    endtask

    task automatic scale_pass(input int s, input int hold, input bit ovr, input int abort_at);
        dl_busy_i = hold > 0;
        for (int w = 0; w < hold; w++) begin
            smp();
            check("hold_sel", int'({src_sel, bram_en}), 2);
            check("hold_scale", int'(scale_o), s);
            step();
        end
        dl_busy_i = 0;
        smp();
        check("wait_sel", int'({src_sel, bram_en, busy_o}), 5);
        check("wait_scale", int'(scale_o), s);
        step();
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) return;
            fft_ready_i = ovr && (i % 2 == 1);
            smp();
            check("run_en", int'({bram_en, bram_we}), 2);
            check("run_addr", int'(bram_addr), i);
            check("run_daddr", int'(daughter_addr), s * N + i);
            check("run_vld", int'(out_valid_o), int'(i >= D));
            check("run_ovr", int'(overrun_o), int'(fft_ready_i));
            check("run_sd", int'(scale_done_o), 0);
            step();
        end
        for (int j = 0; j < D; j++) begin
            fft_ready_i = (j == D - 1) && (s == J1 - 1);
            smp();
            check("drn_en", int'({bram_en, bram_we}), 0);
            check("drn_vld", int'(out_valid_o), 1);
            check("drn_sd", int'(scale_done_o), int'(j == D - 1));
            check("drn_fd", int'(frame_done_o), int'(j == D - 1 && s == J1 - 1));
            check("drn_ovr", int'(overrun_o), int'(fft_ready_i));
            step();
        end
        fft_ready_i = 0;
    endtask

    task automatic run_frame(input bit gap, input int busy_scale, input int hold, input int ovr_scale);
        int v0, s0, f0, o0, c0;
        v0 = n_valid; s0 = n_sd; f0 = n_fd; o0 = n_ovr; c0 = cyc;
        load_frame(gap);
        for (int s = 0; s < J1; s++)
            scale_pass(s, s == busy_scale ? hold : 0, s == ovr_scale, -1);
        check("frm_valid", n_valid - v0, J1 * N);
        check("frm_sd", n_sd - s0, J1);
        check("frm_fd", n_fd - f0, 1);
        check("frm_ovr", n_ovr - o0, 1 + (ovr_scale >= 0 ? N / 2 : 0));
        check("frm_cycles", cyc - c0, (gap ? 2 * N - 1 : N) + J1 * (1 + N + D) + hold);
        check("frm_idle", int'(busy_o), 0);
    endtask

    initial begin
        int s0, f0;
        repeat (3) step();
        rst = 0;
        repeat (10) step();
        smp();
        check("rst_outs", all_out(), 0);
        check("rst_busy", int'(busy_o), 0);
        step();
        run_frame(0, -1, 0, -1);
        run_frame(1, 1, 50, 2);
        load_frame(0);
        scale_pass(0, 0, 0, -1);
        scale_pass(1, 0, 0, -1);
        scale_pass(2, 0, 0, 5);
        rst = 1;
        step();
        rst = 0;
        check("abort_outs", all_out(), 0);
        s0 = n_sd; f0 = n_fd;
        repeat (10) step();
        check("abort_sd", n_sd - s0, 0);
        check("abort_fd", n_fd - f0, 0);
        check("abort_idle", all_out(), 0);
        run_frame(0, -1, 0, -1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cwt_mul_ctrl.md
# cwt_mul_ctrl

Sequencer for the CWT multiply stage. Captures one N-point FFT frame into the shared frame BRAM, then replays it J1 times (once per scale) against the daughter-wavelet BROM. It drives the BRAM/BROM addresses, the BRAM port mux select, and output-valid/done strobes for the complex multiplier. Downlink backpressure is honoured at scale boundaries.

## Interface
- N, 1024, frame length; power of two, ≥ 4
- J1, 4, number of scales; power of two, ≥ 2
- MUL_LAT, 3, multiplier pipeline depth in cycles (BRAM read latency of 1 added internally)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fft_ready_i  in  1  FFT output sample valid, one sample per cycle
- dl_busy_i  in  1  downlink busy; blocks start of next scale
- src_sel  out  1  BRAM port mux: 0 = FFT writes, 1 = multiply reads
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  clog2(N)  BRAM address
- daughter_addr  out  clog2(N*J1)  BROM address = scale*N + n
- scale_o  out  clog2(J1)  current scale index
- out_valid_o  out  1  multiplier output X_re/X_im valid this cycle
- scale_done_o  out  1  one-cycle pulse: last product of current scale
- frame_done_o  out  1  one-cycle pulse: last product of last scale
- overrun_o  out  1  one-cycle pulse: fft_ready_i high while frame cannot be accepted
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, WAIT_DL, RUN, DRAIN.
- IDLE: src_sel=0. If fft_ready_i: write sample 0 (bram_en=bram_we=1, bram_addr=0), n←1, go LOAD.
- LOAD: each cycle with fft_ready_i, write at bram_addr=n, n←n+1. Gaps (fft_ready_i low) hold n with bram_en=0. Write of n=N-1 → n←0, scale←0, go WAIT_DL.
- WAIT_DL: src_sel=1, bram_en=0. If dl_busy_i is low, go RUN next cycle. Otherwise stay.
- RUN: bram_en=1, bram_we=0, bram_addr=n, daughter_addr=scale*N+n, n←n+1 every cycle. On n=N-1 → n←0, go DRAIN. dl_busy_i is ignored inside RUN/DRAIN.
- DRAIN: D=MUL_LAT+1 cycles, bram_en=0. The final DRAIN cycle asserts scale_done_o. If scale=J1-1, it also asserts frame_done_o and the next state is IDLE. Otherwise scale←scale+1 and the next state is WAIT_DL.
- out_valid_o: a D-stage shift register fed by (state==RUN). It is high exactly N cycles per scale, contiguous.
- overrun_o: fft_ready_i high in WAIT_DL, RUN or DRAIN. The sample is dropped and the BRAM is untouched.
- All counters wrap-free. Address arithmetic is unsigned, with daughter_addr formed as {scale, n}.

## Timing
- Reset: state=IDLE; n=0, scale=0. All outputs 0, including src_sel, addresses, strobes and busy_o. The shift register is cleared.
- Reset mid-operation: abort immediately. No scale_done_o/frame_done_o is emitted, and partial BRAM contents are abandoned.
- Load of a gap-free frame: N cycles. The IDLE cycle counts as the first write.
- Scale, from WAIT_DL entry with dl_busy_i low: 1 (WAIT_DL) + N (RUN) + D (DRAIN) cycles.
- First out_valid_o of a scale occurs D cycles after the first RUN cycle.
- The last out_valid_o and scale_done_o share one cycle.
- Back-to-back frames: fft_ready_i in the cycle after frame_done_o is accepted in IDLE.
- fft_ready_i in the same cycle as frame_done_o is an overrun.

## Test plan
- Use N=16, J1=4, MUL_LAT=3 for the directed scenarios below.
- Reset, then idle 10 cycles -> all outputs 0, busy_o=0.
- 16 consecutive fft_ready_i, dl_busy_i=0 -> bram_addr 0..15 with we=1; then 4 × (1+16+4) cycles of RUN/DRAIN.
  - daughter_addr 0..15, 16..31, 32..47, 48..63.
  - 64 out_valid_o total, 4 scale_done_o, 1 frame_done_o.
  - Full frame takes 16+84 cycles.
- Load with fft_ready_i toggling 1,0 -> writes only on high cycles, addresses contiguous 0..15, LOAD lasts 31 cycles.
- dl_busy_i held high for 50 cycles after scale 1 -> WAIT_DL persists 50 cycles, scale_o=1 frozen. RUN starts 1 cycle after release, and out_valid_o count is unchanged.
- fft_ready_i pulsed during RUN of scale 2 -> overrun_o pulses each such cycle, no BRAM write, products unchanged.
- rst asserted mid-RUN of scale 2 -> next cycle all outputs 0 and no done pulses. A new 16-sample frame then completes normally with frame_done_o.
